// File: rtl/lcd_frame_arbiter.sv
// Frame-level controller for the character-LCD write path: runs the init sequence,
// then streams 2x16 frames from the time or msg source into the byte writer.
module lcd_frame_arbiter #(
    parameter int         CLR_WAIT  = 1000,
    parameter logic [7:0] ADDR_ROW1 = 8'h80,
    parameter logic [7:0] ADDR_ROW2 = 8'hC0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         time_req,
    input  logic [127:0] time_row1,
    input  logic [127:0] time_row2,
    output logic         time_done,
    input  logic         msg_req,
    input  logic [127:0] msg_row1,
    input  logic [127:0] msg_row2,
    output logic         msg_done,
    output logic         wr_valid,
    output logic         wr_rs,
    output logic [7:0]   wr_data,
    input  logic         wr_ready,
    output logic         init_done,
    output logic         busy,
    output logic         owner
);

    localparam int WW = (CLR_WAIT > 1) ? $clog2(CLR_WAIT) : 1;

    typedef enum logic [2:0] {
        S_INIT, S_CLR_HOLD, S_IDLE, S_ADDR1, S_ROW1, S_ADDR2, S_ROW2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic [127:0]   row1_q, row1_d, row2_q, row2_d;
    logic           owner_q, owner_d;
    logic           init_done_q, init_done_d;
    logic           time_done_q, time_done_d;
    logic           msg_done_q, msg_done_d;
    logic           wr_valid_q, wr_valid_d;
    logic           wr_rs_q, wr_rs_d;
    logic [7:0]     wr_data_q, wr_data_d;
    logic           acc;
    logic           grant_msg;

    function automatic logic [7:0] row_byte(input logic [127:0] r, input logic [3:0] i);
        logic [6:0] sh;
        sh = {~i, 3'b000};
        return r[sh +: 8];
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h01;
            2'd1:    return 8'h38;
            2'd2:    return 8'h0C;
            default: return 8'h06;
        endcase
    endfunction

    assign acc = wr_valid_q && wr_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        row1_d      = row1_q;
        row2_d      = row2_q;
        owner_d     = owner_q;
        init_done_d = init_done_q;
        time_done_d = 1'b0;
        msg_done_d  = 1'b0;
        grant_msg   = 1'b0;
        case (state_q)
            S_INIT: if (acc) begin
                if (cnt_q == 4'd0) begin
                    state_d = S_CLR_HOLD;
                    wait_d  = '0;
                    cnt_d   = 4'd1;
                end else if (cnt_q == 4'd3) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                    cnt_d       = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_CLR_HOLD: begin
                if (wait_q == WW'(CLR_WAIT - 1)) state_d = S_INIT;
                else                              wait_d  = wait_q + 1'b1;
            end
            S_IDLE: if (init_done_q && (time_req || msg_req)) begin
                // Contention alternates: msg wins unless the previous frame was msg.
                grant_msg = msg_req && !(time_req && owner_q);
                owner_d   = grant_msg;
                row1_d    = grant_msg ? msg_row1 : time_row1;
                row2_d    = grant_msg ? msg_row2 : time_row2;
                cnt_d     = 4'd0;
                state_d   = S_ADDR1;
            end
            S_ADDR1: if (acc) state_d = S_ROW1;
            S_ROW1: if (acc) begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = S_ADDR2;
            end
            S_ADDR2: if (acc) state_d = S_ROW2;
            S_ROW2: if (acc) begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d     = S_IDLE;
                    time_done_d = !owner_q;
                    msg_done_d  = owner_q;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    // Writer outputs are registered from the next state so they are clean out of reset.
    always_comb begin
        wr_valid_d = 1'b0;
        wr_rs_d    = 1'b0;
        wr_data_d  = 8'h00;
        case (state_d)
            S_INIT:  begin wr_valid_d = 1'b1; wr_data_d = init_cmd(cnt_d[1:0]); end
            S_ADDR1: begin wr_valid_d = 1'b1; wr_data_d = ADDR_ROW1; end
            S_ROW1:  begin wr_valid_d = 1'b1; wr_rs_d = 1'b1; wr_data_d = row_byte(row1_d, cnt_d); end
            S_ADDR2: begin wr_valid_d = 1'b1; wr_data_d = ADDR_ROW2; end
            S_ROW2:  begin wr_valid_d = 1'b1; wr_rs_d = 1'b1; wr_data_d = row_byte(row2_d, cnt_d); end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_INIT;
            cnt_q       <= 4'd0;
            wait_q      <= '0;
            row1_q      <= '0;
            row2_q      <= '0;
            owner_q     <= 1'b0;
            init_done_q <= 1'b0;
            time_done_q <= 1'b0;
            msg_done_q  <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_rs_q     <= 1'b0;
            wr_data_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            row1_q      <= row1_d;
            row2_q      <= row2_d;
            owner_q     <= owner_d;
            init_done_q <= init_done_d;
            time_done_q <= time_done_d;
            msg_done_q  <= msg_done_d;
            wr_valid_q  <= wr_valid_d;
            wr_rs_q     <= wr_rs_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign wr_valid  = wr_valid_q;
    assign wr_rs     = wr_rs_q;
    assign wr_data   = wr_data_q;
    assign time_done = time_done_q;
    assign msg_done  = msg_done_q;
    assign init_done = init_done_q;
    assign owner     = owner_q;
    assign busy      = (state_q == S_ADDR1) || (state_q == S_ROW1) ||
                       (state_q == S_ADDR2) || (state_q == S_ROW2);

endmodule

// File: tb/tb_lcd_frame_arbiter.sv
// Randomized bench for lcd_frame_arbiter against a frame-level reference model.
module tb_lcd_frame_arbiter;
    localparam int CLR_WAIT = 40;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         time_req = 1'b0, msg_req = 1'b0, wr_ready = 1'b0;
    logic [127:0] time_row1 = '0, time_row2 = '0, msg_row1 = '0, msg_row2 = '0;
    logic         time_done, msg_done, wr_valid, wr_rs, init_done, busy, owner;
    logic [7:0]   wr_data;

    lcd_frame_arbiter #(.CLR_WAIT(CLR_WAIT)) dut (
        .clk(clk), .rst(rst),
        .time_req(time_req), .time_row1(time_row1), .time_row2(time_row2), .time_done(time_done),
        .msg_req(msg_req), .msg_row1(msg_row1), .msg_row2(msg_row2), .msg_done(msg_done),
        .wr_valid(wr_valid), .wr_rs(wr_rs), .wr_data(wr_data), .wr_ready(wr_ready),
        .init_done(init_done), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    int         checks = 0, errors = 0;
    int         ncyc = 0;
    logic [8:0] acc_q[$];
    int         acc_t[$];
    int         done_q[$];
    bit         rand_rdy = 1'b0;
    bit         last_own = 1'b0;
    bit         stall_prev = 1'b0;
    logic [8:0] stall_val = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Expected transfer k (0..33) of a frame: {rs, byte}.
    function automatic logic [8:0] expb(input int k, input logic [127:0] r1, input logic [127:0] r2);
        if (k == 0)  return {1'b0, 8'h80};
        if (k <= 16) return {1'b1, r1[127 - 8*(k-1) -: 8]};
        if (k == 17) return {1'b0, 8'hC0};
        return {1'b1, r2[127 - 8*(k-18) -: 8]};
    endfunction

    always @(negedge clk) begin
        ncyc++;
        if (rst) begin
            if (stall_prev) begin
                chk("stall_valid", {31'd0, wr_valid}, 32'd1);
                chk("stall_data", {23'd0, wr_rs, wr_data}, {23'd0, stall_val});
            end
            if (wr_valid && wr_ready) begin
                acc_q.push_back({wr_rs, wr_data});
                acc_t.push_back(ncyc);
            end
            if (time_done || msg_done) begin
                chk("done_excl", {31'd0, time_done & msg_done}, 32'd0);
                done_q.push_back(int'(msg_done));
            end
            stall_prev = wr_valid && !wr_ready;
            stall_val  = {wr_rs, wr_data};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) wr_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_q();
        acc_q.delete();
        acc_t.delete();
        done_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
        chk("rst_wr_rs", {31'd0, wr_rs}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
        chk("rst_dones", {30'd0, time_done, msg_done}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_owner", {31'd0, owner}, 32'd0);
        repeat (2) tick();
        clear_q();
        last_own = 1'b0;
        rst = 1'b1;
    endtask

    task automatic init_check();
        int n;
        rand_rdy = 1'b0;
        wr_ready = 1'b1;
        tick();
        chk("init_not_done", {31'd0, init_done}, 32'd0);
        n = 0;
        while (acc_q.size() < 4 && n < CLR_WAIT + 100) begin
            tick();
            n++;
        end
        chk("init_cnt", acc_q.size(), 4);
        if (acc_q.size() >= 4) begin
            chk("init_b0", {23'd0, acc_q[0]}, 32'h001);
            chk("init_b1", {23'd0, acc_q[1]}, 32'h038);
            chk("init_b2", {23'd0, acc_q[2]}, 32'h00C);
            chk("init_b3", {23'd0, acc_q[3]}, 32'h006);
            chk("clr_hold_gap", acc_t[1] - acc_t[0], CLR_WAIT + 1);
            chk("no_bubble", acc_t[3] - acc_t[2], 1);
        end
        chk("init_done", {31'd0, init_done}, 32'd1);
        tick();
        chk("idle_valid", {31'd0, wr_valid}, 32'd0);
        clear_q();
    endtask

    task automatic run_frame(input bit tr, input bit mr, input bit rr, input bit scramble);
        bit           exp_own, first, got_done;
        int           lat;
        logic [127:0] r1, r2;
        rand_rdy = rr;
        if (!rr) wr_ready = 1'b1;
        exp_own  = (tr && mr) ? !last_own : mr;
        last_own = exp_own;
        r1 = exp_own ? msg_row1 : time_row1;
        r2 = exp_own ? msg_row2 : time_row2;
        clear_q();
        time_req = tr;
        msg_req  = mr;
        first = 0; got_done = 0; lat = 0;
        for (int n = 1; n <= 3000 && !got_done; n++) begin
            tick();
            if (!first && acc_q.size() > 0) begin
                first    = 1;
                time_req = 1'b0;
                msg_req  = 1'b0;
                chk("busy_frame", {31'd0, busy}, 32'd1);
                if (scramble) begin
                    time_row1 = {16{8'h20}};
                    time_row2 = rnd128();
                    msg_row1  = rnd128();
                    msg_row2  = rnd128();
                end
            end
            if (time_done || msg_done) begin
                got_done = 1;
                lat = n;
            end
        end
        chk("done_seen", {31'd0, got_done}, 32'd1);
        if (!rr) chk("latency", lat, 35);
        tick();
        chk("busy_idle", {31'd0, busy}, 32'd0);
        chk("done_cnt", done_q.size(), 1);
        if (done_q.size() > 0) chk("done_who", done_q[0], int'(exp_own));
        chk("owner", {31'd0, owner}, {31'd0, exp_own});
        chk("xfer_cnt", acc_q.size(), 34);
        for (int k = 0; k < 34 && k < acc_q.size(); k++)
            chk($sformatf("byte%0d", k), {23'd0, acc_q[k]}, {23'd0, expb(k, r1, r2)});
    endtask

    task automatic contention();
        bit exp_o[4];
        int n;
        rand_rdy = 1'b1;
        clear_q();
        for (int i = 0; i < 4; i++) begin
            exp_o[i] = !last_own;
            last_own = exp_o[i];
        end
        time_req = 1'b1;
        msg_req  = 1'b1;
        n = 0;
        while (done_q.size() < 4 && n < 6000) begin
            tick();
            n++;
            if (acc_q.size() > 3*34) begin
                time_req = 1'b0;
                msg_req  = 1'b0;
            end
        end
        tick();
        chk("cont_done_cnt", done_q.size(), 4);
        chk("cont_xfer_cnt", acc_q.size(), 4*34);
        for (int i = 0; i < 4 && i < done_q.size(); i++)
            chk($sformatf("cont_owner%0d", i), done_q[i], int'(exp_o[i]));
        for (int k = 0; k < 4*34 && k < acc_q.size(); k++)
            chk($sformatf("cont_byte%0d", k), {23'd0, acc_q[k]},
                {23'd0, exp_o[k/34] ? expb(k%34, msg_row1, msg_row2)
                                    : expb(k%34, time_row1, time_row2)});
    endtask

    task automatic reset_mid_frame();
        int n;
        rand_rdy = 1'b0;
        wr_ready = 1'b1;
        clear_q();
        time_req = 1'b1;
        n = 0;
        while (acc_q.size() < 25 && n < 200) begin
            tick();
            n++;
        end
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        time_req = 1'b0;
        do_reset();
        init_check();
    endtask

    initial begin
        bit [1:0] c;
        #3;
        do_reset();
        init_check();

        time_row1 = "0123456789ABCDEF";
        time_row2 = rnd128();
        msg_row1  = rnd128();
        msg_row2  = rnd128();
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        run_frame(1'b0, 1'b1, 1'b0, 1'b0);

        contention();

        run_frame(1'b1, 1'b0, 1'b1, 1'b1);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            c = 2'($urandom_range(1, 3));
            time_row1 = rnd128(); time_row2 = rnd128();
            msg_row1  = rnd128(); msg_row2  = rnd128();
            run_frame(c[0], c[1], 1'($urandom_range(0, 1)), 1'b0);
        end

        reset_mid_frame();
        run_frame(1'b1, 1'b1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_frame_arbiter.md
Name: lcd_frame_arbiter

Overview:
- Frame-level controller and arbiter for the character-LCD write path. Shares one byte-write bus between two content sources:
  - the clock display (time source)
  - an alarm/banner source (msg source)
- After reset it runs the LCD init command sequence. It then streams whole 2x16 frames (address command, 16 characters, address command, 16 characters) from the granted source into the byte writer. The byte writer owns EN pulse timing.
- Sits between the clock/alarm logic and the LCD byte driver.

Parameters:
- CLR_WAIT, 1000: idle clk cycles enforced after the clear-display command is accepted.
- ADDR_ROW1, 8'h80: DDRAM set-address command for row 1.
- ADDR_ROW2, 8'hC0: DDRAM set-address command for row 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- time_req  in  1  level; time source has a frame to show.
- time_row1  in  128  row 1 text; char 0 in [127:120].
- time_row2  in  128  row 2 text; same packing as time_row1.
- time_done  out  1  one-cycle pulse; time frame fully written.
- msg_req  in  1  level; msg source has a frame to show.
- msg_row1  in  128  row 1 text; same packing.
- msg_row2  in  128  row 2 text; same packing.
- msg_done  out  1  one-cycle pulse; msg frame fully written.
- wr_valid  out  1  byte available to the writer.
- wr_rs  out  1  0 = command, 1 = data.
- wr_data  out  8  byte value.
- wr_ready  in  1  writer accepts the byte this cycle.
- init_done  out  1  high once the init sequence is complete.
- busy  out  1  high while a frame is in flight.
- owner  out  1  current or last grant: 0 = time, 1 = msg.

Behaviour:
- Reset (rst low, async): outputs wr_valid=0, wr_rs=0, wr_data=0, time_done=0, msg_done=0, init_done=0, busy=0, owner=0. Internal state goes to INIT, counters clear, alternation flag clears.
- Transfer rule:
  - A byte moves on a cycle where wr_valid && wr_ready.
  - While wr_valid=1 and wr_ready=0, wr_rs and wr_data hold stable.
  - wr_valid is never withdrawn before acceptance.
  - The next byte is presented on the cycle after acceptance; there are no bubbles except CLR_HOLD.
- INIT: presents commands in order 0x01, 0x38, 0x0C, 0x06, all with rs=0.
  - After 0x01 is accepted, enter CLR_HOLD: wr_valid=0 for exactly CLR_WAIT cycles, then continue with 0x38.
  - On acceptance of 0x06, set init_done=1 and go to IDLE.
  - init_done stays 1 until reset.
- IDLE: wr_valid=0, busy=0. Requests are ignored until init_done=1. When any req is high, the arbiter acts in the same cycle:
  - Only one req high: grant that source.
  - Both high: grant msg, unless the previous frame was msg, in which case grant time. This alternates under contention; msg wins ties otherwise.
  - On grant: snapshot both 128-bit rows of the granted source into internal buffers, set owner, then enter ADDR1 on the next cycle with busy=1.
  - Source inputs may change freely after the snapshot; the displayed frame does not tear.
- ADDR1: present ADDR_ROW1 with rs=0.
- ROW1: present 16 bytes with rs=1, taken from the MSB end of the row-1 buffer; 4-bit counter 0..15.
- ADDR2: present ADDR_ROW2 with rs=0.
- ROW2: present 16 bytes with rs=1 from the row-2 buffer.
- After the 16th row-2 byte is accepted:
  - the next cycle pulses the done output of the owner for 1 cycle;
  - busy=0;
  - the FSM returns to IDLE, and may re-grant in that same cycle.
- A frame is exactly 34 transfers. Minimum latency with wr_ready held high: req high in IDLE at cycle N, first byte (0x80) valid at N+1, done pulse at N+35.
- req deasserted mid-frame: the frame still completes and done still pulses. Requests never abort a frame.
- The done pulses are never high simultaneously.
- Reset mid-frame: aborts immediately; the full INIT sequence re-runs, including CLR_HOLD.

Test Plan:
- Init: release rst, wr_ready=1 → accepted bytes 0x01, then CLR_WAIT cycles with wr_valid=0, then 0x38, 0x0C, 0x06 (all rs=0) → init_done=1.
- Time frame: time_req=1, time_row1="0123456789ABCDEF", wr_ready=1 → 0x80, then '0'..'F' with rs=1, then 0xC0 and row 2 → time_done pulses once 35 cycles after grant; owner=0.
- Contention: both req held high for 4 frames → owner sequence msg, time, msg, time; done pulses match.
- Backpressure: wr_ready toggles 1,0,0,1 during ROW1 → wr_data stable while stalled; no byte skipped or duplicated; 34 transfers total.
- Snapshot: change time_row1 to all 0x20 mid-frame → the in-flight frame still emits the original text; the next frame shows spaces.
- Reset mid-ROW2 (rst low for 1 cycle) → wr_valid=0 and init_done=0 immediately; init restarts with 0x01.
